softex_tcdm_splitter: RTL and testbench

- Splits one wide HCI-style TCDM master stream from the SoftEx datapath into MP independent narrow TCDM ports.
- Tolerates per-port grant skew and per-port response skew, which the AND-of-grants binding cannot.
- Sits between the softex_top TCDM interface and the cluster interconnect.
- Each port carries its own handshake: sticky grant tracking on requests, per-port response FIFOs, and a bound on outstanding transactions.

---
 rtl/softex_tcdm_splitter.sv | 171 +++++++++++++++++
 tb/tb_softex_tcdm_splitter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softex_tcdm_splitter.sv
// softex_tcdm_splitter: splits one wide HCI-style TCDM master stream into
// MP independent narrow TCDM ports with per-port grant and response skew.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   in_req_i/in_gnt_o    wide request handshake (in_add_i, in_wen_i,
//                        in_be_i, in_data_i, in_id_i held until grant)
//   in_r_*               wide response: valid/ready, data (slice i from
//                        port i), id (port 0), opc (OR of all ports)
//   out_req_o/out_gnt_i  per-port request handshake with sliced fields
//   out_r_*              per-port response stream into per-port FIFOs
module softex_tcdm_splitter #(
    parameter int unsigned MP          = 4,
    parameter int unsigned PORT_DW     = 64,
    parameter int unsigned AW          = 32,
    parameter int unsigned IW          = 8,
    parameter int unsigned ADDR_STRIDE = 8,
    parameter int unsigned RSP_DEPTH   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // wide side
    input  logic                      in_req_i,
    output logic                      in_gnt_o,
    input  logic [AW-1:0]             in_add_i,
    input  logic                      in_wen_i,
    input  logic [MP*PORT_DW/8-1:0]   in_be_i,
    input  logic [MP*PORT_DW-1:0]     in_data_i,
    input  logic [IW-1:0]             in_id_i,
    input  logic                      in_r_ready_i,
    output logic                      in_r_valid_o,
    output logic [MP*PORT_DW-1:0]     in_r_data_o,
    output logic [IW-1:0]             in_r_id_o,
    output logic                      in_r_opc_o,
    // narrow side
    output logic [MP-1:0]             out_req_o,
    input  logic [MP-1:0]             out_gnt_i,
    output logic [MP*AW-1:0]          out_add_o,
    output logic [MP-1:0]             out_wen_o,
    output logic [MP*PORT_DW/8-1:0]   out_be_o,
    output logic [MP*PORT_DW-1:0]     out_data_o,
    output logic [MP*IW-1:0]          out_id_o,
    output logic [MP-1:0]             out_r_ready_o,
    input  logic [MP-1:0]             out_r_valid_i,
    input  logic [MP*PORT_DW-1:0]     out_r_data_i,
    input  logic [MP*IW-1:0]          out_r_id_i,
    input  logic [MP-1:0]             out_r_opc_i
);

    localparam int unsigned BW = PORT_DW / 8;
    localparam int unsigned EW = PORT_DW + IW + 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(RSP_DEPTH - 1);

    logic [MP-1:0]         granted_q;
    logic [CW-1:0]         cnt_q;
    logic                  can_issue;
    logic                  wide_gnt;
    logic                  pop;
    logic [MP-1:0]         full;
    logic [MP-1:0]         empty;
    logic [MP-1:0]         push;
    logic [MP-1:0][EW-1:0] head;
    logic [MP-1:0][IW-1:0] head_id;
    logic [MP-1:0]         head_opc;
    logic                  unused_head_id;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // The outstanding bound is what keeps every FIFO from overflowing
    // when one port answers before its siblings are even granted.
    assign can_issue = cnt_q < DEPTH;

    // Ports already granted for this transaction count as granted, so the
    // wide grant fires in the same cycle the last port grants.
    assign wide_gnt  = in_req_i & can_issue & (&(granted_q | out_gnt_i));
    assign in_gnt_o  = wide_gnt;
    assign out_req_o = {MP{in_req_i & can_issue}} & ~granted_q;

    assign in_r_valid_o  = ~|empty;
    assign pop           = in_r_valid_o & in_r_ready_i;
    assign out_r_ready_o = ~full;
    assign push          = out_r_valid_i & ~full;

    assign in_r_id_o      = head_id[0];
    assign in_r_opc_o     = |head_opc;
    assign unused_head_id = ^head_id;

    for (genvar i = 0; i < MP; i++) begin : g_port
        logic [EW-1:0] mem_q [RSP_DEPTH];
        logic [PW-1:0] wptr_q;
        logic [PW-1:0] rptr_q;
        logic [CW-1:0] fcnt_q;

        assign out_add_o[i*AW +: AW]   = in_add_i + AW'(i * ADDR_STRIDE);
        assign out_wen_o[i]            = in_wen_i;
        assign out_be_o[i*BW +: BW]    = in_be_i[i*BW +: BW];
        assign out_data_o[i*PORT_DW +: PORT_DW] =
            in_data_i[i*PORT_DW +: PORT_DW];
        assign out_id_o[i*IW +: IW]    = in_id_i;

        assign full[i]  = fcnt_q == DEPTH;
        assign empty[i] = fcnt_q == '0;
        assign head[i]  = mem_q[rptr_q];

        assign in_r_data_o[i*PORT_DW +: PORT_DW] = head[i][EW-1 -: PORT_DW];
        assign head_id[i]  = head[i][IW:1];
        assign head_opc[i] = head[i][0];

        always_ff @(posedge clk_i) begin
            if (push[i]) begin
                mem_q[wptr_q] <= {out_r_data_i[i*PORT_DW +: PORT_DW],
                                  out_r_id_i[i*IW +: IW],
                                  out_r_opc_i[i]};
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                fcnt_q <= '0;
            end else begin
                if (push[i]) wptr_q <= nxt(wptr_q);
                if (pop)     rptr_q <= nxt(rptr_q);
                case ({push[i], pop})
                    2'b10:   fcnt_q <= fcnt_q + 1'b1;
                    2'b01:   fcnt_q <= fcnt_q - 1'b1;
                    default: fcnt_q <= fcnt_q;
                endcase
            end
        end

`ifndef SYNTHESIS
        // Narrow requests granted but not yet answered on this port; a
        // response arriving with none pending is a narrow-side bug.
        logic [CW:0] iss_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                iss_q <= '0;
            end else begin
                a_rsp_has_req : assert (!push[i] || iss_q != '0);
                case ({out_req_o[i] & out_gnt_i[i], push[i]})
                    2'b10:   iss_q <= iss_q + 1'b1;
                    2'b01:   iss_q <= iss_q - 1'b1;
                    default: iss_q <= iss_q;
                endcase
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            granted_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (wide_gnt) granted_q <= '0;
            else          granted_q <= granted_q | (out_req_o & out_gnt_i);
            if (wide_gnt && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !wide_gnt) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_softex_tcdm_splitter.sv
// Directed bench for softex_tcdm_splitter: stimulus pushes expected wide
// responses into a scoreboard that a separate monitor pops and compares.
module tb_softex_tcdm_splitter;

    localparam int MP = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_req;
    logic               in_gnt_o;
    logic [AW-1:0]      in_add;
    logic               in_wen;
    logic [MP*DW/8-1:0] in_be;
    logic [MP*DW-1:0]   in_data;
    logic [IW-1:0]      in_id;
    logic               in_r_ready;
    logic               in_r_valid_o;
    logic [MP*DW-1:0]   in_r_data_o;
    logic [IW-1:0]      in_r_id_o;
    logic               in_r_opc_o;
    logic [MP-1:0]      out_req_o;
    logic [MP-1:0]      gnt;
    logic [MP*AW-1:0]   out_add_o;
    logic [MP-1:0]      out_wen_o;
    logic [MP*DW/8-1:0] out_be_o;
    logic [MP*DW-1:0]   out_data_o;
    logic [MP*IW-1:0]   out_id_o;
    logic [MP-1:0]      out_r_ready_o;
    logic [MP-1:0]      r_valid;
    logic [MP*DW-1:0]   r_data;
    logic [MP*IW-1:0]   r_id;
    logic [MP-1:0]      r_opc;

    softex_tcdm_splitter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_req_i      (in_req),
        .in_gnt_o      (in_gnt_o),
        .in_add_i      (in_add),
        .in_wen_i      (in_wen),
        .in_be_i       (in_be),
        .in_data_i     (in_data),
        .in_id_i       (in_id),
        .in_r_ready_i  (in_r_ready),
        .in_r_valid_o  (in_r_valid_o),
        .in_r_data_o   (in_r_data_o),
        .in_r_id_o     (in_r_id_o),
        .in_r_opc_o    (in_r_opc_o),
        .out_req_o     (out_req_o),
        .out_gnt_i     (gnt),
        .out_add_o     (out_add_o),
        .out_wen_o     (out_wen_o),
        .out_be_o      (out_be_o),
        .out_data_o    (out_data_o),
        .out_id_o      (out_id_o),
        .out_r_ready_o (out_r_ready_o),
        .out_r_valid_i (r_valid),
        .out_r_data_i  (r_data),
        .out_r_id_i    (r_id),
        .out_r_opc_i   (r_opc)
    );

    typedef struct packed {
        logic [MP*DW-1:0] data;
        logic [IW-1:0]    id;
        logic             opc;
    } rsp_t;

    rsp_t sb[$];
    rsp_t exp_r;
    int   checks = 0;
    int   errors = 0;
    int   gcnt[MP];

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        in_req  = 1'b0;
        gnt     = '0;
        r_valid = '0;
    endtask

    task automatic req(input logic [AW-1:0] a, input logic [IW-1:0] id,
                       input logic [MP-1:0] g);
        in_req = 1'b1;
        in_add = a;
        in_id  = id;
        gnt    = g;
    endtask

    task automatic set_rsp(input logic [MP-1:0] v, input logic [15:0] base,
                           input logic [IW-1:0] id);
        r_valid = v;
        r_data  = {48'h0, base + 16'd3, 48'h0, base + 16'd2,
                   48'h0, base + 16'd1, 48'h0, base};
        r_id    = {MP{id}};
        r_opc   = '0;
    endtask

    task automatic expect_rsp(input logic [15:0] base, input logic [IW-1:0] id,
                              input logic opc);
        rsp_t e;
        e.data = {48'h0, base + 16'd3, 48'h0, base + 16'd2,
                  48'h0, base + 16'd1, 48'h0, base};
        e.id   = id;
        e.opc  = opc;
        sb.push_back(e);
    endtask

    // Response monitor: compares every accepted wide response in order.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && in_r_valid_o && in_r_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %0h expected none",
                             in_r_data_o);
                end else begin
                    exp_r = sb.pop_front();
                    chk("rsp_data", in_r_data_o, exp_r.data);
                    chk("rsp_id", in_r_id_o, exp_r.id);
                    chk("rsp_opc", in_r_opc_o, exp_r.opc);
                end
            end
        end
    end

    // Narrow grant counter, used to catch re-requests of granted ports.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            for (int p = 0; p < MP; p++)
                if (out_req_o[p] && gnt[p]) gcnt[p]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        idle();
        in_add     = '0;
        in_wen     = 1'b1;
        in_be      = '1;
        in_data    = '0;
        in_id      = '0;
        in_r_ready = 1'b1;
        r_data     = '0;
        r_id       = '0;
        r_opc      = '0;
        repeat (2) cyc();
        #1;
        chk("rst_req", out_req_o, 4'h0);
        chk("rst_gnt", in_gnt_o, 1'b0);
        chk("rst_rvalid", in_r_valid_o, 1'b0);
        chk("rst_rready", out_r_ready_o, 4'hf);
        chk("rst_cnt", dut.cnt_q, 0);
        cyc();
        rst = 1'b0;

        // Aligned grants
        cyc();
        req(32'h100, 8'h11, 4'hf);
        in_data = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        in_be   = 32'hF00F_0FF0;
        #1;
        chk("al_gnt", in_gnt_o, 1'b1);
        chk("al_req", out_req_o, 4'hf);
        chk("al_add", out_add_o, {32'h118, 32'h110, 32'h108, 32'h100});
        chk("al_data", out_data_o, {64'hD3, 64'hD2, 64'hD1, 64'hD0});
        chk("al_be", out_be_o, 32'hF00F_0FF0);
        chk("al_id", out_id_o, 32'h11111111);
        chk("al_wen", out_wen_o, 4'hf);
        expect_rsp(16'h1000, 8'h11, 1'b0);
        cyc();
        idle();
        #1;
        chk("al_cnt", dut.cnt_q, 1);
        cyc();
        set_rsp(4'hf, 16'h1000, 8'h11);
        #1;
        chk("al_rvalid_early", in_r_valid_o, 1'b0);
        cyc();
        r_valid = '0;
        #1;
        chk("al_rvalid", in_r_valid_o, 1'b1);
        cyc();
        #1;
        chk("al_cnt_done", dut.cnt_q, 0);

        // Skewed grants: port 2 grants three cycles after the others
        cyc();
        for (int p = 0; p < MP; p++) gcnt[p] = 0;
        req(32'h200, 8'h22, 4'b1011);
        #1;
        chk("sk_req0", out_req_o, 4'hf);
        chk("sk_gnt0", in_gnt_o, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            cyc();
            #1;
            chk("sk_req_wait", out_req_o, 4'b0100);
            chk("sk_gnt_wait", in_gnt_o, 1'b0);
        end
        cyc();
        gnt = 4'b0100;
        #1;
        chk("sk_req3", out_req_o, 4'b0100);
        chk("sk_gnt3", in_gnt_o, 1'b1);
        expect_rsp(16'h000A, 8'h22, 1'b1);
        cyc();
        idle();
        #1;
        for (int p = 0; p < MP; p++) chk("sk_one_grant", gcnt[p], 1);

        // Skewed responses: port 0 early, ports 1..3 late, port 2 errors
        cyc();
        r_valid = 4'b0001;
        r_data  = {64'hD, 64'hC, 64'hB, 64'hA};
        r_id    = {8'h33, 8'h33, 8'h33, 8'h22};
        r_opc   = 4'b0000;
        #1;
        chk("sr_valid_t2", in_r_valid_o, 1'b0);
        for (int k = 3; k <= 4; k++) begin
            cyc();
            r_valid = '0;
            #1;
            chk("sr_valid_wait", in_r_valid_o, 1'b0);
        end
        cyc();
        r_valid = 4'b1110;
        r_opc   = 4'b0100;
        #1;
        chk("sr_valid_t5", in_r_valid_o, 1'b0);
        cyc();
        r_valid = '0;
        r_opc   = '0;
        #1;
        chk("sr_valid_t6", in_r_valid_o, 1'b1);
        cyc();
        #1;
        chk("sr_cnt", dut.cnt_q, 0);

        // Backpressure: third read held until one response is popped
        cyc();
        in_r_ready = 1'b0;
        req(32'h300, 8'h01, 4'hf);
        #1;
        chk("bp_gnt0", in_gnt_o, 1'b1);
        expect_rsp(16'h3100, 8'h01, 1'b0);
        cyc();
        req(32'h340, 8'h02, 4'hf);
        #1;
        chk("bp_gnt1", in_gnt_o, 1'b1);
        expect_rsp(16'h3200, 8'h02, 1'b0);
        cyc();
        req(32'h380, 8'h03, 4'hf);
        set_rsp(4'hf, 16'h3100, 8'h01);
        #1;
        chk("bp_req2", out_req_o, 4'h0);
        chk("bp_gnt2", in_gnt_o, 1'b0);
        chk("bp_cnt2", dut.cnt_q, 2);
        cyc();
        set_rsp(4'hf, 16'h3200, 8'h02);
        #1;
        chk("bp_req3", out_req_o, 4'h0);
        cyc();
        r_valid = '0;
        #1;
        chk("bp_full", out_r_ready_o, 4'h0);
        chk("bp_rvalid", in_r_valid_o, 1'b1);
        chk("bp_req4", out_req_o, 4'h0);
        cyc();
        in_r_ready = 1'b1;
        #1;
        chk("bp_req_pop", out_req_o, 4'h0);
        cyc();
        in_r_ready = 1'b0;
        #1;
        chk("bp_req_after", out_req_o, 4'hf);
        chk("bp_gnt_after", in_gnt_o, 1'b1);
        expect_rsp(16'h3300, 8'h03, 1'b0);
        cyc();
        idle();
        in_r_ready = 1'b1;
        #1;
        chk("bp_cnt_re", dut.cnt_q, 2);
        cyc();
        set_rsp(4'hf, 16'h3300, 8'h03);
        #1;
        chk("bp_cnt_1", dut.cnt_q, 1);
        cyc();
        r_valid = '0;
        cyc();
        #1;
        chk("bp_cnt_0", dut.cnt_q, 0);

        // Address wrap, then grant and pop in the same cycle
        cyc();
        in_r_ready = 1'b0;
        req(32'hFFFF_FFF8, 8'h05, 4'hf);
        #1;
        chk("wr_add", out_add_o,
            {32'h0000_0010, 32'h0000_0008, 32'h0000_0000, 32'hFFFF_FFF8});
        expect_rsp(16'h5000, 8'h05, 1'b0);
        cyc();
        idle();
        set_rsp(4'hf, 16'h5000, 8'h05);
        cyc();
        r_valid    = '0;
        in_r_ready = 1'b1;
        req(32'h500, 8'h06, 4'hf);
        #1;
        chk("sim_gnt", in_gnt_o, 1'b1);
        chk("sim_rvalid", in_r_valid_o, 1'b1);
        chk("sim_cnt_pre", dut.cnt_q, 1);
        expect_rsp(16'h6000, 8'h06, 1'b0);
        cyc();
        idle();
        #1;
        chk("sim_cnt", dut.cnt_q, 1);
        cyc();
        set_rsp(4'hf, 16'h6000, 8'h06);
        cyc();
        r_valid = '0;
        cyc();
        #1;
        chk("sim_cnt_0", dut.cnt_q, 0);

        // Reset with buffered responses and a partially granted request
        cyc();
        in_r_ready = 1'b0;
        req(32'h700, 8'h07, 4'hf);
        #1;
        chk("rm_gnt0", in_gnt_o, 1'b1);
        expect_rsp(16'h7000, 8'h07, 1'b0);
        cyc();
        idle();
        set_rsp(4'b0011, 16'h7000, 8'h07);
        cyc();
        r_valid = '0;
        req(32'h740, 8'h08, 4'b0011);
        #1;
        chk("rm_req", out_req_o, 4'hf);
        chk("rm_gnt1", in_gnt_o, 1'b0);
        cyc();
        gnt = '0;
        #1;
        chk("rm_granted", dut.granted_q, 4'b0011);
        chk("rm_req_rest", out_req_o, 4'b1100);
        cyc();
        rst = 1'b1;
        idle();
        sb.delete();
        cyc();
        rst = 1'b0;
        #1;
        chk("rm_rvalid", in_r_valid_o, 1'b0);
        chk("rm_cnt", dut.cnt_q, 0);
        chk("rm_req0", out_req_o, 4'h0);
        chk("rm_granted0", dut.granted_q, 4'h0);
        chk("rm_rready", out_r_ready_o, 4'hf);
        cyc();
        req(32'h800, 8'h09, 4'hf);
        #1;
        chk("rm_req_new", out_req_o, 4'hf);
        chk("rm_gnt_new", in_gnt_o, 1'b1);
        expect_rsp(16'h9000, 8'h09, 1'b0);
        cyc();
        idle();
        in_r_ready = 1'b1;
        set_rsp(4'hf, 16'h9000, 8'h09);
        cyc();
        r_valid = '0;

        for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
        cyc();
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("end_cnt", dut.cnt_q, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
